// File: rtl/sort_pkg.sv
// Shared types and helpers for the odd-even transposition sorter.
//   state_e    : LOAD / SORT / DRAIN controller states
//   cnt_width  : width of a counter that spans 0..n-1 (at least 1 bit)
//   PHASE_EVEN / PHASE_ODD : parity of phase_cnt selecting the active pair set
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_e;

  localparam int unsigned PHASE_EVEN = 0;
  localparam int unsigned PHASE_ODD  = 1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmp_exch.sv
// Compare-exchange cell for one adjacent buffer pair.
//   a, b    : entries at index i and i+1
//   lo_out  : value that belongs at index i after the exchange
//   hi_out  : value that belongs at index i+1 after the exchange
//   swap    : exchange taken (strictly out of order; ties never swap)
//   a_gt_b, b_gt_a, eq : raw ordering flags under the SIGNED setting
module cmp_exch #(
  parameter int unsigned DATA_W  = 16,
  parameter bit          SIGNED  = 1'b1,
  parameter bit          DESCEND = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] hi_out,
  output logic              swap,
  output logic              a_gt_b,
  output logic              b_gt_a,
  output logic              eq
);

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  logic [DATA_W-1:0] key_a, key_b;
  assign key_a = {a[DATA_W-1] ^ SIGNED, a[DATA_W-2:0]};
  assign key_b = {b[DATA_W-1] ^ SIGNED, b[DATA_W-2:0]};

  assign a_gt_b = key_a > key_b;
  assign b_gt_a = key_b > key_a;
  assign eq     = key_a == key_b;

  assign swap   = DESCEND ? b_gt_a : a_gt_b;
  assign lo_out = swap ? b : a;
  assign hi_out = swap ? a : b;

endmodule

// File: rtl/oet_sorter.sv
// Block sorter: loads DEPTH samples, sorts them in place with odd-even
// transposition (one phase per cycle, DEPTH phases), then streams them out.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     : sample input stream (accepted in LOAD)
//   out_valid/out_ready/out_data  : sorted output stream (driven in DRAIN)
//   out_last                      : final sample of the frame
//   busy                          : high in SORT or DRAIN
//   swap_cnt                      : exchanges in the last sort; present only
//                                   when OET_SORTER_SWAP_CNT_EN is defined
module oet_sorter
  import sort_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 8,
  parameter bit          SIGNED  = 1'b1,
  parameter bit          DESCEND = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
`ifdef OET_SORTER_SWAP_CNT_EN
  output logic              busy,
  output logic [$clog2(DEPTH*DEPTH/2+1)-1:0] swap_cnt
`else
  output logic              busy
`endif
);

  localparam int unsigned     CntW    = cnt_width(DEPTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0] One     = CntW'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DATA_W-1:0] sorted [DEPTH];
  logic [CntW-1:0]   load_cnt_q, load_cnt_d;
  logic [CntW-1:0]   phase_cnt_q, phase_cnt_d;
  logic [CntW-1:0]   drain_cnt_q, drain_cnt_d;

  logic [DATA_W-1:0] lo [DEPTH-1];
  logic [DATA_W-1:0] hi [DEPTH-1];
  logic [DEPTH-2:0]  swp, gt, lt, eq;
  logic [DEPTH-2:0]  pair_act;
  logic              phase_odd;

  assign phase_odd = (int'(phase_cnt_q[0]) == PHASE_ODD);

  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_pair
    cmp_exch #(
      .DATA_W (DATA_W),
      .SIGNED (SIGNED),
      .DESCEND(DESCEND)
    ) u_cmp (
      .a     (data_q[i]),
      .b     (data_q[i+1]),
      .lo_out(lo[i]),
      .hi_out(hi[i]),
      .swap  (swp[i]),
      .a_gt_b(gt[i]),
      .b_gt_a(lt[i]),
      .eq    (eq[i])
    );

    // Pair i is active when its lower index parity matches the phase parity.
    assign pair_act[i] = ((i % 2 == PHASE_ODD) == phase_odd);

    always_comb begin
      assert ($onehot({gt[i], lt[i], eq[i]}));
      assert (!(eq[i] && swp[i]));
    end
  end

  // Active pairs within one phase are disjoint, so they all apply at once.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) sorted[k] = data_q[k];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (pair_act[i]) begin
        sorted[i]   = lo[i];
        sorted[i+1] = hi[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    load_cnt_d  = load_cnt_q;
    phase_cnt_d = phase_cnt_q;
    drain_cnt_d = drain_cnt_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d[load_cnt_q] = in_data;
          if (load_cnt_q == LastIdx) begin
            load_cnt_d  = '0;
            phase_cnt_d = '0;
            state_d     = SORT;
          end else begin
            load_cnt_d = load_cnt_q + One;
          end
        end
      end
      SORT: begin
        busy   = 1'b1;
        data_d = sorted;
        if (phase_cnt_q == LastIdx) begin
          phase_cnt_d = '0;
          state_d     = DRAIN;
        end else begin
          phase_cnt_d = phase_cnt_q + One;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = data_q[0];
        out_last  = (drain_cnt_q == LastIdx);
        if (out_ready) begin
          for (int i = 0; i < DEPTH - 1; i++) data_d[i] = data_q[i+1];
          data_d[DEPTH-1] = '0;
          if (drain_cnt_q == LastIdx) begin
            drain_cnt_d = '0;
            state_d     = LOAD;
          end else begin
            drain_cnt_d = drain_cnt_q + One;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      load_cnt_q  <= '0;
      phase_cnt_q <= '0;
      drain_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      data_q      <= data_d;
    end
  end

`ifdef OET_SORTER_SWAP_CNT_EN
  localparam int unsigned SwW = $clog2(DEPTH*DEPTH/2+1);

  logic [SwW-1:0] swaps_now;
  logic [SwW-1:0] swap_cnt_q;

  always_comb begin
    swaps_now = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (pair_act[i] && swp[i]) swaps_now = swaps_now + SwW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt_q <= '0;
    end else if (state_q == LOAD && in_valid && load_cnt_q == LastIdx) begin
      swap_cnt_q <= '0;
    end else if (state_q == SORT) begin
      swap_cnt_q <= swap_cnt_q + swaps_now;
    end
  end

  assign swap_cnt = swap_cnt_q;
`endif

endmodule

// File: tb/tb_oet_sorter.sv
// Bench for oet_sorter: four instances (signed ascending, unsigned,
// descending, DEPTH=2) share clock, reset, in_data and out_ready; each has its
// own in_valid. Expected outputs are queued by the stimulus and popped by a
// negedge monitor. OET_SORTER_SWAP_CNT_EN additionally checks swap_cnt.
module tb_oet_sorter;

  typedef struct packed {
    logic [1:0]  k;
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  iv;
  logic        out_ready;
  logic        ir [4];
  logic        ov [4];
  logic        ol [4];
  logic        bz [4];
  logic [15:0] od [4];
`ifdef OET_SORTER_SWAP_CNT_EN
  logic [5:0]  sc0, sc1, sc2;
  logic [1:0]  sc3;
`endif

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  oet_sorter #(.DATA_W(16), .DEPTH(8), .SIGNED(1'b1), .DESCEND(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]),
`ifdef OET_SORTER_SWAP_CNT_EN
    .swap_cnt(sc0),
`endif
    .busy(bz[0]));

  oet_sorter #(.DATA_W(16), .DEPTH(8), .SIGNED(1'b0), .DESCEND(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]),
`ifdef OET_SORTER_SWAP_CNT_EN
    .swap_cnt(sc1),
`endif
    .busy(bz[1]));

  oet_sorter #(.DATA_W(16), .DEPTH(8), .SIGNED(1'b1), .DESCEND(1'b1)) u_desc (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2]),
`ifdef OET_SORTER_SWAP_CNT_EN
    .swap_cnt(sc2),
`endif
    .busy(bz[2]));

  oet_sorter #(.DATA_W(16), .DEPTH(2), .SIGNED(1'b1), .DESCEND(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .out_last(ol[3]),
`ifdef OET_SORTER_SWAP_CNT_EN
    .swap_cnt(sc3),
`endif
    .busy(bz[3]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Cycles from the last input handshake to the first out_valid.
  function automatic int exp_lat(input int k);
    return (k == 3) ? 3 : 9;
  endfunction

  // ---------------- monitor ----------------
  int          lat_cnt [4];
  bit          armed [4];
  bit          stall [4];
  logic [15:0] stall_d [4];
  logic        stall_l [4];
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        armed[k] = 1'b0;
        stall[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (armed[k]) lat_cnt[k]++;
        if (ov[k] && armed[k]) begin
          chk($sformatf("latency[%0d]", k), lat_cnt[k], exp_lat(k));
          armed[k] = 1'b0;
        end
        if (iv[k] && ir[k]) begin
          armed[k]   = 1'b1;
          lat_cnt[k] = 0;
        end
        if (stall[k]) begin
          chk($sformatf("hold valid[%0d]", k), ov[k], 1);
          chk($sformatf("hold data[%0d]", k), od[k], stall_d[k]);
          chk($sformatf("hold last[%0d]", k), ol[k], stall_l[k]);
        end
        stall[k]   = ov[k] && !out_ready;
        stall_d[k] = od[k];
        stall_l[k] = ol[k];
        if (ov[k] && out_ready) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected output[%0d]: got %0h expected none", k, od[k]);
          end else begin
            e = sb.pop_front();
            chk("out source", k, e.k);
            chk($sformatf("out data[%0d]", k), od[k], e.d);
            chk($sformatf("out last[%0d]", k), ol[k], e.l);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] vin [8];
  logic [15:0] vexp [8];

  task automatic expect_frame(input int k, input logic [15:0] v [8], input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.k = 2'(k);
      x.d = v[i];
      x.l = (i == n - 1);
      sb.push_back(x);
    end
  endtask

  task automatic load(input int k, input logic [15:0] v [8], input int n);
    for (int i = 0; i < n; i++) begin
      in_data = v[i];
      iv[k]   = 1'b1;
      @(posedge clk); #1;
    end
    iv[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && ir[k] && !bz[k]) return;
      @(posedge clk); #1;
    end
    n_total++;
    $display("FAIL timeout[%0d]: got pending %0d expected 0", k, sb.size());
  endtask

  initial begin
    rst_n     = 1'b1;
    iv        = '0;
    in_data   = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst in_ready[%0d]", k), ir[k], 1);
      chk($sformatf("rst out_valid[%0d]", k), ov[k], 0);
      chk($sformatf("rst out_data[%0d]", k), od[k], 0);
      chk($sformatf("rst out_last[%0d]", k), ol[k], 0);
      chk($sformatf("rst busy[%0d]", k), bz[k], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed ascending with extremes and a tie.
    vin  = '{16'd5, 16'hFFFD, 16'd7, 16'd0, 16'h8000, 16'h7FFF, 16'd2, 16'd2};
    vexp = '{16'h8000, 16'hFFFD, 16'h0000, 16'h0002, 16'h0002, 16'h0005, 16'h0007, 16'h7FFF};
    expect_frame(0, vexp, 8);
    load(0, vin, 8);
    chk("busy in sort", bz[0], 1);
    chk("in_ready in sort", ir[0], 0);
    wait_done(0);

    // Unsigned compare, same inputs.
    vexp = '{16'h0000, 16'h0002, 16'h0002, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'hFFFD};
    expect_frame(1, vexp, 8);
    load(1, vin, 8);
    wait_done(1);

    // Descending, fully reversed input order.
    vin  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    vexp = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    expect_frame(2, vexp, 8);
    load(2, vin, 8);
    wait_done(2);
`ifdef OET_SORTER_SWAP_CNT_EN
    chk("swap_cnt desc", sc2, 28);
`endif

    // Backpressure with in_valid=99 pushed during DRAIN.
    vin  = '{16'd40, 16'd10, 16'd30, 16'd20, 16'd80, 16'd60, 16'd70, 16'd50};
    vexp = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    expect_frame(0, vexp, 8);
    load(0, vin, 8);
    for (int i = 0; i < 50; i++) begin
      if (ov[0]) break;
      @(posedge clk); #1;
    end
    for (int p = 0; p < 100; p++) begin
      if (ir[0]) break;
      out_ready = (p % 4 == 0) || (p % 4 == 3);
      in_data   = 16'd99;
      iv[0]     = 1'b1;
      @(posedge clk); #1;
    end
    iv[0]     = 1'b0;
    out_ready = 1'b1;
    wait_done(0);
    vin  = '{16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd7};
    vexp = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    expect_frame(0, vexp, 8);
    load(0, vin, 8);
    wait_done(0);

    // Reset abort during sort phase 3; the frame is discarded.
    vin = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    load(0, vin, 8);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort in_ready", ir[0], 1);
    chk("abort out_valid", ov[0], 0);
    chk("abort busy", bz[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    vin  = '{16'd8, 16'd8, 16'd8, 16'd8, 16'd1, 16'd1, 16'd1, 16'd1};
    vexp = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd8, 16'd8, 16'd8, 16'd8};
    expect_frame(0, vexp, 8);
    load(0, vin, 8);
    wait_done(0);

    // DEPTH=2.
    vin  = '{16'd9, 16'hFFFC, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vexp = '{16'hFFFC, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    expect_frame(3, vexp, 2);
    load(3, vin, 2);
    wait_done(3);

    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/oet_sorter.md
Name: oet_sorter

Overview:
- Parametrised block-sort engine for the image sorting datapath; successor to the fixed 16-bit combinational comparator.
- Accepts a frame of DEPTH samples over a valid/ready stream and sorts them in place with odd-even transposition, one phase per cycle.
- Streams the sorted frame out over a second valid/ready stream.
- Sits between the pixel window buffer and the median/rank selector.

Parameters:
- DATA_W, 16, sample width in bits (>=2)
- DEPTH, 8, samples per frame (even, >=2)
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare
- DESCEND, 0, 0 = ascending output order, 1 = descending

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  high while loading
- in_data  in  DATA_W  input sample
- out_valid  out  1  sorted sample valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  sorted sample
- out_last  out  1  marks final sample of frame
- busy  out  1  high in SORT or DRAIN

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=LOAD, all buffer entries=0, counters=0. Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- FSM has three states: LOAD, SORT, DRAIN.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write in_data to buf[load_cnt] and increment load_cnt.
  - On the transfer where load_cnt==DEPTH-1: go to SORT, clear load_cnt.
- SORT:
  - in_ready=0, busy=1. Runs exactly DEPTH cycles, tracked by phase_cnt 0..DEPTH-1.
  - Even phase: compare-exchange pairs (0,1),(2,3),...
  - Odd phase: compare-exchange pairs (1,2),(3,4),...,(DEPTH-3,DEPTH-2).
  - All pairs in a phase update in the same cycle.
  - Exchange when buf[i] > buf[i+1] for ascending, or buf[i] < buf[i+1] for descending.
  - Ties never exchange, so the sort is stable.
  - After phase DEPTH-1, go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=buf[0], out_last=(drain_cnt==DEPTH-1).
  - On out_valid&&out_ready: shift buf down one entry, fill the top with 0, increment drain_cnt.
  - On the final transfer: return to LOAD, clear drain_cnt.
  - out_ready low holds out_data/out_last stable (AXI-style, no retraction).
- Latency: first sorted sample valid DEPTH+1 cycles after the clock edge that accepted the last input.
- Throughput: one frame per 3*DEPTH cycles minimum; there is no overlap of load and drain.
- Arithmetic:
  - Comparison only, no width growth.
  - SIGNED=1: 16'h8000 is the minimum, 16'h7FFF is the maximum.
  - SIGNED=0: 16'h0000 is the minimum.
- Boundaries:
  - in_valid while not in LOAD is ignored (in_ready=0, no write).
  - out_ready while not in DRAIN has no effect.
  - DEPTH=2: the odd phase has no pairs and holds the buffer.
  - rst_n low mid-LOAD/SORT/DRAIN aborts immediately, discards the frame and returns to reset values.

Optional Feature:
- Macro: OET_SORTER_SWAP_CNT_EN.
- Defined:
  - Adds output swap_cnt [$clog2(DEPTH*DEPTH/2+1)-1:0].
  - Counts total exchanges performed during SORT; cleared on entry to SORT.
  - Holds its value through DRAIN and LOAD until the next SORT; reset value 0.
  - Used for presortedness profiling.
- Not defined: port absent, no counter logic; the rest of the behaviour is identical.

Decomposition:
- Package sort_pkg:
  - state enum {LOAD, SORT, DRAIN};
  - function clog2-based counter width;
  - localparams PHASE_EVEN=0, PHASE_ODD=1.
- Sub-module cmp_exch:
  - Parameters DATA_W, SIGNED, DESCEND.
  - Inputs a, b. Outputs lo_out, hi_out, swap, a_gt_b, b_gt_a, eq.
  - Generalises the existing comparator.
  - Instantiated DEPTH-1 times via generate; the parent muxes even/odd pair results.

Test Plan:
- Ascending, signed, DEPTH=8, DATA_W=16. Load 5,-3,7,0,-32768,32767,2,2 with out_ready=1. Expected out: -32768,-3,0,2,2,5,7,32767, out_last on the 8th sample only, first out_valid 9 cycles after the last input.
- SIGNED=0, same inputs. Expected: 16'h0000,0x0002,0x0002,0x0005,0x0007,0x7FFF,0x8000,0xFFFD.
- DESCEND=1, load 1..8. Expected out: 8,7,...,1. With OET_SORTER_SWAP_CNT_EN, swap_cnt=28.
- Backpressure: toggle out_ready 1,0,0,1 during DRAIN. out_data stays stable while stalled, no sample dropped or duplicated. in_valid=1 with in_data=99 during DRAIN is ignored and does not appear in the next frame.
- Reset abort: assert rst_n=0 for 1 cycle at SORT phase 3. Expected: in_ready=1, out_valid=0, busy=0 immediately. The next frame 8,8,8,8,1,1,1,1 outputs 1,1,1,1,8,8,8,8.
- DEPTH=2: load 9,-4. Expected out -4,9 with out_last on -4=0, 9=1, latency 3 cycles.
